// File: rtl/seq_detector.sv
// Serial pattern detector: programmable pattern/length with overlapping or non-overlapping matching.
// Build option: define SEQ_DET_COUNT_EN to include the saturating match counter and its clr input.
module seq_detector #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned LEN_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap_en,
    input  logic             clr,
    output logic             detect,
    output logic             armed,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               detect_q, detect_d;
    logic               armed_q, armed_d;

    logic [PAT_W-1:0]   len_mask;
    logic [PAT_W-1:0]   hist_shift;
    logic [FILL_W-1:0]  fill_inc;
    logic               accept;
    logic               len_ok;
    logic               fill_enough;
    logic               match;

    // Bit i is compared only when it lies inside the active pattern length.
    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < 32'(len_q));
        end
    end

    assign accept      = din_valid && !cfg_load && (state_q != IDLE);
    assign len_ok      = (pat_len != '0) && (32'(pat_len) <= PAT_W);
    assign hist_shift  = {hist_q[PAT_W-2:0], din};
    assign fill_inc    = (32'(fill_q) >= PAT_W) ? fill_q : fill_q + FILL_W'(1);
    assign fill_enough = (32'(fill_q) + 32'd1) >= 32'(len_q);
    assign match       = accept && fill_enough &&
                         ((hist_shift & len_mask) == (pat_q & len_mask));

    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        pat_d    = pat_q;
        len_d    = len_q;
        detect_d = 1'b0;

        if (cfg_load) begin
            pat_d   = pat;
            len_d   = pat_len;
            hist_d  = '0;
            fill_d  = '0;
            state_d = len_ok ? FILL : IDLE;
        end else if (accept) begin
            hist_d   = hist_shift;
            detect_d = match;
            if (match && !overlap_en) begin
                // Non-overlapping: the next match must be built from fresh bits.
                fill_d  = '0;
                state_d = FILL;
            end else begin
                fill_d  = fill_inc;
                state_d = ((32'(fill_inc) + 32'd1) >= 32'(len_q)) ? ARMED : FILL;
            end
        end

        armed_d = (state_d == ARMED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hist_q   <= '0;
            fill_q   <= '0;
            pat_q    <= '0;
            len_q    <= '0;
            detect_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            detect_q <= detect_d;
            armed_q  <= armed_d;
        end
    end

    assign detect = detect_q;
    assign armed  = armed_q;

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // clr wins over a coincident match; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_count = cnt_q;
`else
    logic unused_clr;
    assign unused_clr  = clr;
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: expected detect bits are queued with each stimulus cycle.
module tb_seq_detector;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned LEN_W = 6;

`ifdef SEQ_DET_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             din;
    logic             din_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] pat_len;
    logic             overlap_en;
    logic             clr;
    logic             detect;
    logic             armed;
    logic [CNT_W-1:0] match_count;

    logic  exp_q[$];
    int    n_chk;
    int    n_err;
    string phase;

    seq_detector #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W),
        .LEN_W(LEN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .cfg_load   (cfg_load),
        .pat        (pat),
        .pat_len    (pat_len),
        .overlap_en (overlap_en),
        .clr        (clr),
        .detect     (detect),
        .armed      (armed),
        .match_count(match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h", phase, tag, act, exp);
        end
    endtask

    function automatic logic [31:0] cexp(input int v);
        return CNT_EN ? 32'(v) : 32'd0;
    endfunction

    task automatic sb_pop();
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            chk("detect", 32'(detect), 32'(exp_q.pop_front()));
        end
    endtask

    // One clock of stimulus; detect is checked one cycle later.
    task automatic step(input logic v, input logic b, input logic c, input logic e);
        din_valid = v;
        din       = b;
        clr       = c;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        clr       = 1'b0;
        sb_pop();
    endtask

    task automatic cfg(input logic [7:0] p, input logic [5:0] l, input logic ov, input logic dv);
        cfg_load   = 1'b1;
        pat        = p;
        pat_len    = l;
        overlap_en = ov;
        din_valid  = dv;
        din        = 1'b0;
        exp_q.push_back(1'b0);
        @(posedge clk);
        #1;
        cfg_load  = 1'b0;
        din_valid = 1'b0;
        sb_pop();
    endtask

    // Bits and expected detects are given first-bit-in-MSB over n positions.
    task automatic stream(input logic [15:0] bits, input logic [15:0] exp, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            step(1'b1, bits[n-1-i], 1'b0, exp[n-1-i]);
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        n_chk      = 0;
        n_err      = 0;
        phase      = "reset";
        rst_n      = 1'b0;
        din        = 1'b0;
        din_valid  = 1'b0;
        cfg_load   = 1'b0;
        pat        = '0;
        pat_len    = '0;
        overlap_en = 1'b0;
        clr        = 1'b0;
        #12;
        chk("detect", 32'(detect), 32'd0);
        chk("armed", 32'(armed), 32'd0);
        chk("count", 32'(match_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        phase = "idle";
        stream(16'b0110110, 16'b0000000, 7, 0);
        chk("armed", 32'(armed), 32'd0);

        phase = "overlap";
        cfg(8'h06, 6'd4, 1'b1, 1'b0);
        chk("armed_fill", 32'(armed), 32'd0);
        stream(16'b011, 16'b000, 3, 0);
        chk("armed_ready", 32'(armed), 32'd1);
        stream(16'b0110, 16'b1001, 4, 0);
        chk("armed", 32'(armed), 32'd1);
        chk("count", 32'(match_count), cexp(2));

        phase = "nonoverlap";
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("count_clr", 32'(match_count), 32'd0);
        cfg(8'h06, 6'd4, 1'b0, 1'b0);
        stream(16'b0110, 16'b0001, 4, 0);
        chk("armed_after_match", 32'(armed), 32'd0);
        stream(16'b1100110, 16'b0000001, 7, 0);
        chk("count", 32'(match_count), cexp(2));

        phase = "gaps";
        step(1'b0, 1'b0, 1'b1, 1'b0);
        cfg(8'h06, 6'd4, 1'b1, 1'b0);
        stream(16'b0110, 16'b0001, 4, 3);
        chk("count", 32'(match_count), cexp(1));

        phase = "saturate";
        step(1'b0, 1'b0, 1'b1, 1'b0);
        cfg(8'h01, 6'd1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
        end
        chk("count_sat", 32'(match_count), cexp(3));
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("count_clr_match", 32'(match_count), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        phase = "cfg_priority";
        cfg(8'h06, 6'd4, 1'b1, 1'b1);
        stream(16'b1100110, 16'b0000001, 7, 0);

        phase = "midreset";
        cfg(8'h06, 6'd4, 1'b1, 1'b0);
        stream(16'b011, 16'b000, 3, 0);
        chk("armed_pre", 32'(armed), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("armed_rst", 32'(armed), 32'd0);
        chk("detect_rst", 32'(detect), 32'd0);
        chk("count_rst", 32'(match_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stream(16'b0, 16'b0, 1, 0);
        stream(16'b01100110, 16'b00000000, 8, 0);
        chk("armed", 32'(armed), 32'd0);

        phase = "badlen";
        cfg(8'h06, 6'd9, 1'b1, 1'b0);
        chk("armed_cfg", 32'(armed), 32'd0);
        stream(16'b0110110, 16'b0000000, 7, 0);
        chk("armed", 32'(armed), 32'd0);
        cfg(8'h06, 6'd0, 1'b1, 1'b0);
        stream(16'b0110, 16'b0000, 4, 0);
        chk("armed_len0", 32'(armed), 32'd0);

        phase = "end";
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter PAT_W, default 8: maximum pattern length in bits; legal range 2..32.
REQ-002 Parameter CNT_W, default 8: width of the match counter.
REQ-003 Parameter LEN_W, default 6: width of pat_len; SHALL be able to hold PAT_W.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 din  in  1  serial data bit.
REQ-007 din_valid  in  1  din sampled only on cycles where this is 1.
REQ-008 cfg_load  in  1  single-cycle pulse; latches pat and pat_len.
REQ-009 pat  in  PAT_W  pattern; pat[pat_len-1] is the first bit received, pat[0] the last.
REQ-010 pat_len  in  LEN_W  pattern length.
REQ-011 overlap_en  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-012 clr  in  1  synchronous clear of match_count.
REQ-013 detect  out  1  registered one-cycle match pulse.
REQ-014 armed  out  1  high while state is ARMED.
REQ-015 match_count  out  CNT_W  saturating count of matches.

Function
REQ-016 The block SHALL hold:
- a PAT_W-bit history shift register: newest bit in history[0] on each accepted din;
- a fill counter saturating at PAT_W;
- latched copies of pat and pat_len.
REQ-017 The FSM SHALL have three states, with these transitions:
- IDLE -> FILL on cfg_load with 1 <= pat_len <= PAT_W;
- FILL -> ARMED when the fill count reaches pat_len - 1;
- ARMED -> FILL after a match when overlap_en = 0.
REQ-018 cfg_load with pat_len = 0 or pat_len > PAT_W SHALL move the FSM to IDLE; detect SHALL never assert in IDLE.
REQ-019 cfg_load SHALL clear the history and fill count, and takes priority over din_valid; a din presented in the same cycle is discarded.
REQ-020 A match occurs on an accepted bit when fill + 1 >= pat_len and the post-shift history[pat_len-1:0] equals the latched pat[pat_len-1:0].
REQ-021 detect SHALL be high for exactly the one cycle following the clock edge that accepted the completing bit (latency 1), and low otherwise.
REQ-022 With overlap_en = 1, a match SHALL retain the history and fill count, so a match can occur on any subsequent accepted bit.
REQ-023 With overlap_en = 0, a match SHALL reset the fill count to 0, so the next match needs pat_len new bits.
REQ-024 Cycles with din_valid = 0 SHALL leave history, fill, state and match_count unchanged, and detect SHALL be 0.
REQ-025 match_count SHALL increment on each match and saturate at 2^CNT_W - 1 (no wrap).
REQ-026 clr SHALL set match_count to 0; clr in the same cycle as a match yields count 0, while detect still pulses.
REQ-027 overlap_en changes SHALL take effect on the next accepted bit.

Reset
REQ-028 While rst_n = 0, the block SHALL immediately force:
- state IDLE;
- detect 0, armed 0, match_count 0;
- history, fill count, latched pat and latched pat_len all 0.
REQ-029 Reset asserted mid-stream SHALL discard any partial match; after release the block SHALL need a new cfg_load before any detect.

Configuration
REQ-030 Macro SEQ_DET_COUNT_EN: when defined, match_count and clr behave per REQ-025/026.
REQ-031 When SEQ_DET_COUNT_EN is undefined, there SHALL be no counter logic, match_count SHALL be constant 0, and clr SHALL be ignored; ports remain present.

Verification
REQ-032 PAT_W=8: cfg_load pat=8'h06, pat_len=4, overlap_en=1; stream 0,1,1,0,1,1,0 -> detect after bits 4 and 7; match_count=2.
REQ-033 Same stream with overlap_en=0 -> detect after bit 4 only; appending 0,1,1,0 -> second detect after bit 11; match_count=2.
REQ-034 pat_len=4, pat=8'h06, stream 0,1,1,0 with din_valid=0 gaps of 3 cycles between bits -> single detect one cycle after the 4th accepted edge, no extra pulses.
REQ-035 CNT_W=2, pat_len=1, pat=8'h01, five accepted 1s -> five detects; match_count sticks at 3; clr coincident with the 5th match -> match_count=0.
REQ-036 Stream 0,1,1, then rst_n low for 1 cycle, then 0 -> no detect; cfg_load pat_len=9 (PAT_W=8) -> armed stays 0 and no detect on any stream.
